adc_scheduler: RTL and testbench

Channel sequencer for the LTC2308 ADC interface. It drives the interface's channel select and round-robins over an enable mask. It also services one-shot priority requests and captures every conversion into a per-channel result bank. The ADC interface has no completion strobe, so this block tracks conversions with a frame counter locked to that interface's fixed 18-cycle conversion loop. Both blocks share clk and reset_n.

---
 rtl/adc_scheduler_pkg.sv | 21 ++
 rtl/adc_scheduler_if.sv | 21 ++
 rtl/adc_scheduler_rr_pick.sv | 28 ++
 rtl/adc_scheduler.sv | 145 ++++++++++++++
 tb/tb_adc_scheduler.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_scheduler_pkg.sv
// rtl/adc_scheduler_pkg.sv - shared constants, tag and request-state types for adc_scheduler
package adc_pkg;

  localparam int CONV_PERIOD = 18;
  localparam int NUM_CH      = 8;
  localparam int RES_W       = 12;

  // One conversion in flight: which channel it was and whether a request asked for it
  typedef struct packed {
    logic       valid;
    logic [2:0] chan;
    logic       is_req;
  } tag_t;

  typedef enum logic [1:0] {
    REQ_IDLE   = 2'd0,
    REQ_PEND   = 2'd1,
    REQ_FLIGHT = 2'd2
  } req_state_t;

endpackage

// File: rtl/adc_scheduler_if.sv
// rtl/adc_scheduler_if.sv - priority request / response port of adc_scheduler
interface adc_scheduler_if;
  import adc_pkg::*;

  logic             req_valid;
  logic [2:0]       req_chan;
  logic             req_ready;
  logic             resp_valid;
  logic [RES_W-1:0] resp_data;

  modport master (
    output req_valid, req_chan,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_chan,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/adc_scheduler_rr_pick.sv
// rtl/adc_scheduler_rr_pick.sv - next enabled channel strictly above a pointer, wrapping
module adc_rr_pick
  import adc_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [2:0]        ptr,
  output logic [2:0]        chan,
  output logic              found
);

  logic [2:0] cand;

  // Walk offsets from farthest to nearest so the nearest enabled channel wins;
  // offset NUM_CH wraps back to the pointer itself as the last resort
  always_comb begin
    chan  = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = ptr + 3'(i);
      if (mask[cand]) begin
        chan  = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_scheduler.sv
// rtl/adc_scheduler.sv - LTC2308 channel sequencer with priority requests and result bank; ADCSCHED_AVG_EN enables IIR bank filtering
module adc_scheduler
  import adc_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [RES_W-1:0]        adc_result,
  output logic [2:0]              adc_chan,
  adc_scheduler_if.slave          req_if,
  output logic [NUM_CH*RES_W-1:0] ch_data,
  output logic [NUM_CH-1:0]       ch_valid,
  output logic                    sample_stb
);

  logic [4:0]       phase;
  logic             dec;
  logic             req_take;
  logic [2:0]       scan_ptr;
  logic [2:0]       req_chan_q;
  logic [2:0]       pick_chan;
  logic             pick_found;
  logic [2:0]       next_chan;
  tag_t             next_tag;
  tag_t             tag_issue;
  tag_t             tag_data;
  req_state_t       req_state;
  logic [RES_W-1:0] bank_next;

  assign dec      = (phase == 5'(CONV_PERIOD - 1));
  assign req_take = req_if.req_valid && req_if.req_ready;

  adc_rr_pick u_pick (
    .mask  (ch_en),
    .ptr   (scan_ptr),
    .chan  (pick_chan),
    .found (pick_found)
  );

  // Frame counter in lockstep with the ADC interface loop (same reset, same period)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  phase <= '0;
    else if (dec)  phase <= '0;
    else           phase <= phase + 5'd1;
  end

  // Channel for the next frame: pending or just-accepted request, else round-robin, else hold
  always_comb begin
    next_tag  = '0;
    next_chan = adc_chan;
    if (req_state == REQ_PEND) begin
      next_tag  = {1'b1, req_chan_q, 1'b1};
      next_chan = req_chan_q;
    end else if (req_take) begin
      next_tag  = {1'b1, req_if.req_chan, 1'b1};
      next_chan = req_if.req_chan;
    end else if (pick_found) begin
      next_tag  = {1'b1, pick_chan, 1'b0};
      next_chan = pick_chan;
    end
  end

  // Decision edge: drive the new channel and shift the two-deep tag pipeline
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      adc_chan  <= '0;
      scan_ptr  <= 3'd7;
      tag_issue <= '0;
      tag_data  <= '0;
    end else if (dec) begin
      adc_chan  <= next_chan;
      tag_issue <= next_tag;
      tag_data  <= tag_issue;
      if (next_tag.valid && !next_tag.is_req) scan_ptr <= next_chan;
    end
  end

  // Request handshake: one request outstanding, ready returns the cycle after the response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_state        <= REQ_IDLE;
      req_chan_q       <= '0;
      req_if.req_ready <= 1'b1;
    end else begin
      if (req_take)               req_if.req_ready <= 1'b0;
      else if (req_if.resp_valid) req_if.req_ready <= 1'b1;
      case (req_state)
        REQ_IDLE: begin
          if (req_take) begin
            req_chan_q <= req_if.req_chan;
            req_state  <= dec ? REQ_FLIGHT : REQ_PEND;
          end
        end
        REQ_PEND:   if (dec) req_state <= REQ_FLIGHT;
        REQ_FLIGHT: if (dec && tag_data.valid && tag_data.is_req) req_state <= REQ_IDLE;
        default:    req_state <= REQ_IDLE;
      endcase
    end
  end

`ifdef ADCSCHED_AVG_EN
  logic [RES_W-1:0]        bank_old;
  logic signed [RES_W:0]   avg_diff;
  logic signed [RES_W:0]   avg_step;
  logic [RES_W:0]          avg_sum;

  // Quarter-step IIR toward the new sample; a channel's first write loads it directly
  always_comb begin
    bank_old = '0;
    for (int n = 0; n < NUM_CH; n++)
      if (tag_data.chan == 3'(n)) bank_old = ch_data[n*RES_W +: RES_W];
    avg_diff  = $signed({1'b0, adc_result}) - $signed({1'b0, bank_old});
    avg_step  = avg_diff >>> 2;
    avg_sum   = {1'b0, bank_old} + avg_step;
    bank_next = ch_valid[tag_data.chan] ? avg_sum[RES_W-1:0] : adc_result;
  end
`else
  assign bank_next = adc_result;
`endif

  // Capture the result belonging to tag_data into the bank and answer requests
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_data           <= '0;
      ch_valid          <= '0;
      sample_stb        <= 1'b0;
      req_if.resp_valid <= 1'b0;
      req_if.resp_data  <= '0;
    end else begin
      sample_stb        <= 1'b0;
      req_if.resp_valid <= 1'b0;
      if (dec && tag_data.valid) begin
        for (int n = 0; n < NUM_CH; n++)
          if (tag_data.chan == 3'(n)) ch_data[n*RES_W +: RES_W] <= bank_next;
        ch_valid[tag_data.chan] <= 1'b1;
        sample_stb              <= 1'b1;
        if (tag_data.is_req) begin
          req_if.resp_valid <= 1'b1;
          req_if.resp_data  <= adc_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_scheduler.sv
// tb/tb_adc_scheduler.sv - scoreboard bench for adc_scheduler with a frame-locked ADC model
module tb_adc_scheduler;
  import adc_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  ch_en;
  logic [11:0] adc_result;
  logic [2:0]  adc_chan;
  logic [95:0] ch_data;
  logic [7:0]  ch_valid;
  logic        sample_stb;

  adc_scheduler_if bus ();

  adc_scheduler dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ch_en      (ch_en),
    .adc_result (adc_result),
    .adc_chan   (adc_chan),
    .req_if     (bus.slave),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .sample_stb (sample_stb)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Frame/phase reference shared with the ADC model
  int tb_phase = 0;
  int tb_frame = 0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tb_phase <= 0;
      tb_frame <= 0;
    end else if (tb_phase == CONV_PERIOD - 1) begin
      tb_phase <= 0;
      tb_frame <= tb_frame + 1;
    end else begin
      tb_phase <= tb_phase + 1;
    end
  end

  // ADC model: channel sampled at phase 0, its result presented during the next frame
  logic [11:0] adc_val [8];
  logic [2:0]  conv_chan;
  always @(negedge clk) begin
    if (reset_n && tb_phase == 0) begin
      adc_result = adc_val[conv_chan];
      conv_chan  = adc_chan;
    end
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (frame %0d phase %0d)", name, act, exp, tb_frame, tb_phase);
    end
  endtask

  typedef struct { int frame; int chan; logic [11:0] data; } wr_exp_t;
  typedef struct { int frame; logic [11:0] data; } rsp_exp_t;
  wr_exp_t  wr_q [$];
  rsp_exp_t rsp_q [$];
  wr_exp_t  we;
  rsp_exp_t re;

  // Monitor: every bank write / response is checked against the next queued expectation
  always @(negedge clk) begin
    if (reset_n) begin
      if (sample_stb) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_sample_stb", sample_stb, 1'b0);
        end else begin
          we = wr_q.pop_front();
          chk("wr_frame", tb_frame, we.frame);
          chk("wr_phase", tb_phase, 0);
          chk("wr_data", ch_data[we.chan*12 +: 12], we.data);
          chk("wr_valid", ch_valid[we.chan], 1'b1);
        end
      end
      if (bus.resp_valid) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_resp_valid", bus.resp_valid, 1'b0);
        end else begin
          re = rsp_q.pop_front();
          chk("resp_frame", tb_frame, re.frame);
          chk("resp_data", bus.resp_data, re.data);
        end
      end
    end
  end

  task automatic wait_at(input int f, input int p);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(tb_frame == f && tb_phase == p) && guard < 3000);
    if (guard >= 3000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_at: reached frame %0d phase %0d, required frame %0d phase %0d", tb_frame, tb_phase, f, p);
    end
  endtask

  task automatic do_reset(input logic [7:0] mask);
    @(negedge clk);
    reset_n = 1'b0;
    ch_en   = mask;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_adc_chan"}, adc_chan, 3'd0);
    chk({pfx, "_ch_data"}, ch_data, 96'd0);
    chk({pfx, "_ch_valid"}, ch_valid, 8'd0);
    chk({pfx, "_sample_stb"}, sample_stb, 1'b0);
    chk({pfx, "_req_ready"}, bus.req_ready, 1'b1);
    chk({pfx, "_resp_valid"}, bus.resp_valid, 1'b0);
    chk({pfx, "_resp_data"}, bus.resp_data, 12'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    ch_en         = 8'h00;
    bus.req_valid = 1'b0;
    bus.req_chan  = 3'd0;
    adc_result    = 12'h000;
    conv_chan     = 3'd0;
    for (int c = 0; c < 8; c++) adc_val[c] = 12'h100 + 12'(c);
    repeat (3) @(negedge clk);
    check_reset_vals("init");

    // Empty mask: channel held at 0, nothing written
    reset_n = 1'b1;
    for (int f = 1; f <= 4; f++) begin
      wait_at(f, 0);
      chk("mask0_adc_chan", adc_chan, 3'd0);
    end
    chk("mask0_ch_valid", ch_valid, 8'h00);

    // Mask 01 with a mid-frame request for channel 5
    wr_q.push_back('{3, 0, 12'h100});
    wr_q.push_back('{4, 0, 12'h100});
    wr_q.push_back('{5, 5, 12'h105});
    wr_q.push_back('{6, 0, 12'h100});
    wr_q.push_back('{7, 0, 12'h100});
    rsp_q.push_back('{5, 12'h105});
    do_reset(8'h01);
    wait_at(2, 5);
    bus.req_valid = 1'b1;
    bus.req_chan  = 3'd5;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("req_ready_low_after_accept", bus.req_ready, 1'b0);
    wait_at(3, 0);
    chk("req_issue_chan5", adc_chan, 3'd5);
    wait_at(4, 0);
    chk("scan_resumes_chan0", adc_chan, 3'd0);
    wait_at(5, 0);
    chk("req_ready_low_during_resp", bus.req_ready, 1'b0);
    @(negedge clk);
    chk("req_ready_back_high", bus.req_ready, 1'b1);
    wait_at(6, 0);
    chk("ch_data5_kept", ch_data[5*12 +: 12], 12'h105);

    // Reset mid-frame at phase 9
    wait_at(7, 9);
    reset_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    chk("midrst_wr_q_drained", wr_q.size(), 0);
    chk("midrst_rsp_q_drained", rsp_q.size(), 0);

    // Mask 05 after mid-frame reset: first valid capture two frames later
    wr_q.push_back('{3, 0, 12'h100});
    wr_q.push_back('{4, 2, 12'h102});
    wr_q.push_back('{5, 0, 12'h100});
    wr_q.push_back('{6, 2, 12'h102});
    ch_en = 8'h05;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    wait_at(1, 0);
    chk("rr_chan_f1", adc_chan, 3'd0);
    wait_at(2, 0);
    chk("rr_chan_f2", adc_chan, 3'd2);
    wait_at(3, 0);
    chk("rr_chan_f3", adc_chan, 3'd0);
    wait_at(3, 1);
    chk("rr_ch_valid_f3", ch_valid, 8'h01);
    chk("rr_ch_data0_f3", ch_data[11:0], 12'h100);
    wait_at(4, 0);
    chk("rr_chan_f4", adc_chan, 3'd2);
    wait_at(4, 1);
    chk("rr_ch_valid_f4", ch_valid, 8'h05);
    wait_at(6, 5);
    chk("rr_wr_q_drained", wr_q.size(), 0);

    // Request presented on the decision cycle is issued at that same edge
    wr_q.push_back('{4, 3, 12'h103});
    rsp_q.push_back('{4, 12'h103});
    do_reset(8'h00);
    wait_at(1, CONV_PERIOD - 1);
    bus.req_valid = 1'b1;
    bus.req_chan  = 3'd3;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("edge_req_chan3", adc_chan, 3'd3);
    chk("edge_req_ready_low", bus.req_ready, 1'b0);
    chk("edge_req_flight", dut.req_state, REQ_FLIGHT);
    wait_at(3, 0);
    chk("edge_req_chan_held", adc_chan, 3'd3);
    wait_at(4, 1);
    chk("edge_req_ready_high", bus.req_ready, 1'b1);
    chk("edge_wr_q_drained", wr_q.size(), 0);
    chk("edge_rsp_q_drained", rsp_q.size(), 0);

    // Channel 1 samples 400, 000, 000
    adc_val[1] = 12'h400;
`ifdef ADCSCHED_AVG_EN
    wr_q.push_back('{3, 1, 12'h400});
    wr_q.push_back('{4, 1, 12'h300});
    wr_q.push_back('{5, 1, 12'h240});
`else
    wr_q.push_back('{3, 1, 12'h400});
    wr_q.push_back('{4, 1, 12'h000});
    wr_q.push_back('{5, 1, 12'h000});
`endif
    do_reset(8'h02);
    wait_at(2, 5);
    adc_val[1] = 12'h000;
    wait_at(5, 5);
    chk("avg_wr_q_drained", wr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end

endmodule
